// File: rtl/mem_access_ctrl.sv
// Single-outstanding request/response controller in front of the on-chip memory macro.
// Valid follows accept by 1 (overflow), 2 (write) or RD_LAT+2 (read) cycles; ready stays low until then.
module mem_access_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int MEM_AW = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] input_bus,
  output logic              ready,
  output logic [DATA_W-1:0] output_bus,
  output logic              valid,
  output logic              addr_overflow,
  output logic              mem_en,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_RD, RESP} state_t;

  state_t     state;
  logic       rw_q;
  logic [2:0] cnt;
  logic       ovf;

  // Full-width memory space cannot overflow, and the upper slice would be empty.
  generate
    if (MEM_AW < ADDR_W) begin : g_ovf
      assign ovf = |address[ADDR_W-1:MEM_AW];
    end else begin : g_no_ovf
      assign ovf = 1'b0;
    end
  endgenerate

  assign ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rw_q          <= 1'b0;
      cnt           <= '0;
      output_bus    <= '0;
      valid         <= 1'b0;
      addr_overflow <= 1'b0;
      mem_en        <= 1'b0;
      mem_rd_en     <= 1'b0;
      mem_wr_en     <= 1'b0;
      mem_addr      <= '0;
      mem_din       <= '0;
    end else begin
      mem_en        <= 1'b0;
      mem_rd_en     <= 1'b0;
      mem_wr_en     <= 1'b0;
      valid         <= 1'b0;
      addr_overflow <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            rw_q <= rw;
            if (ovf) begin
              // Out-of-range: respond immediately, memory never sees it.
              state         <= RESP;
              valid         <= 1'b1;
              addr_overflow <= 1'b1;
              if (!rw) output_bus <= '0;
            end else begin
              state     <= ACCESS;
              mem_en    <= 1'b1;
              mem_rd_en <= !rw;
              mem_wr_en <= rw;
              mem_addr  <= address[MEM_AW-1:0];
              mem_din   <= input_bus;
            end
          end
        end
        ACCESS: begin
          if (rw_q) begin
            state <= RESP;
            valid <= 1'b1;
          end else begin
            state <= WAIT_RD;
            cnt   <= 3'(RD_LAT - 1);
          end
        end
        WAIT_RD: begin
          if (cnt == 3'd0) begin
            output_bus <= mem_dout;
            state      <= RESP;
            valid      <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Parametrised request/response controller between the processor datapath and the on-chip `memory` macro. It accepts one transaction at a time via a req/ready handshake and issues a single-cycle strobe to the memory. Reads wait a configurable memory read latency; every accepted transaction is acknowledged with a one-cycle valid pulse. Out-of-range addresses are flagged and never reach the memory.

Parameters:
DATA_W, 16, data bus width (input_bus, output_bus, mem_din, mem_dout)
ADDR_W, 16, processor address width
MEM_AW, 12, memory address width; legal range MEM_AW <= ADDR_W; with MEM_AW == ADDR_W overflow never occurs
RD_LAT, 1, memory read latency in cycles, from the edge sampling mem_en to mem_dout valid; legal range 1..8

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
req  in  1  transaction request
rw  in  1  0 = READ, 1 = WRITE; sampled with req
address  in  ADDR_W  byte-less word address; sampled with req
input_bus  in  DATA_W  write data; sampled with req
ready  out  1  controller idle, can accept req
output_bus  out  DATA_W  read data, registered
valid  out  1  one-cycle completion pulse, for reads and writes
addr_overflow  out  1  qualifies valid: transaction was out of range
mem_en  out  1  memory enable
mem_rd_en  out  1  memory read strobe
mem_wr_en  out  1  memory write strobe
mem_addr  out  MEM_AW  memory address
mem_din  out  DATA_W  memory write data
mem_dout  in  DATA_W  memory read data

Behaviour:
- Reset (rst_n low at an edge): state IDLE; ready=1; valid=0; addr_overflow=0; output_bus=0; mem_en, mem_rd_en and mem_wr_en all 0; mem_addr=0; mem_din=0; latency counter=0.
- Reset mid-operation aborts the transaction. No valid is produced, and strobes are low from the next cycle.
- ready = (state == IDLE), registered-state decode. Accept occurs at edge E0 when req && ready. At E0 the controller latches rw, address and input_bus. req while ready=0 is ignored and not queued.
- Overflow check: ovf = |address[ADDR_W-1:MEM_AW], evaluated on the accepted address.
- States:
  - IDLE: on accept with ovf -> RESP. On accept with !ovf -> ACCESS.
  - ACCESS: one cycle. mem_en=1; mem_rd_en=!rw; mem_wr_en=rw. mem_addr = latched address[MEM_AW-1:0]; mem_din = latched data. Write -> RESP. Read -> WAIT, counter loaded with RD_LAT-1.
  - WAIT: counter decrements each cycle. When it reaches 0, the edge leaving WAIT captures mem_dout into output_bus and moves to RESP. Strobes are 0.
  - RESP: one cycle. valid=1. addr_overflow=1 only if the transaction overflowed. Then -> IDLE.
- Latency, measured from accept edge E0 to the cycle in which valid is high:
  - Overflow: cycle after E0.
  - Write: cycle after E1.
  - Read: cycle after E(RD_LAT+1).
- Throughput: minimum accept-to-accept spacing is 2 cycles (overflow), 3 cycles (write), RD_LAT+3 cycles (read).
- Overflowed transaction: no mem strobe at all. For a read, output_bus is cleared to 0. For a write, output_bus holds its value.
- output_bus holds its last value between reads; it is updated only by a read completion or a read overflow.
- mem_addr and mem_din hold their last values outside ACCESS.
- valid and addr_overflow are 0 outside RESP.
- rw, address and input_bus may change freely after accept without effect on the transaction.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req=1 -> ready=1, valid=0, all strobes 0, output_bus=0. No accept occurs until rst_n=1.
- Write then read, RD_LAT=1: write address=0x0123, data=0xBEEF -> mem_wr_en high exactly 1 cycle with mem_addr=0x123, mem_din=0xBEEF; valid 2 cycles after accept. Then read 0x0123 -> mem_rd_en 1 cycle; valid 3 cycles after accept with output_bus=0xBEEF, addr_overflow=0.
- RD_LAT=4 read: memory model returns 0x5A5A 4 cycles after the strobe -> valid exactly 6 cycles after accept, output_bus=0x5A5A, ready low throughout.
- Overflow: read address=0x1000 -> no mem_en; valid and addr_overflow high together 1 cycle after accept; output_bus=0. Write address=0xF000 -> no mem_wr_en; addr_overflow=1; output_bus unchanged.
- Busy/back-to-back: hold req=1 continuously with alternating write 0x0001 and read 0x0001 -> accepts only when ready=1, one valid per accept, strobes never overlap.
- Reset mid-read (RD_LAT=4): drive rst_n=0 during WAIT -> no valid pulse; state IDLE and ready=1 after release; output_bus=0.
